// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// 4x4 active-low matrix keypad scanner with press/release debouncing.
// The 1 kHz input is sampled as data; each synchronized rising edge is one scan tick.
module keypad_scanner #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk1khz,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB  = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;
  logic          valid_q, valid_d;

  logic       ck_meta_q, ck_sync_q, ck_prev_q;
  logic [3:0] rows_meta_q, rows_s_q;
  logic       tick, any_low, cand_rel;
  logic [1:0] det_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_meta_q   <= 1'b0;
      ck_sync_q   <= 1'b0;
      ck_prev_q   <= 1'b0;
      rows_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
    end else begin
      ck_meta_q   <= clk1khz;
      ck_sync_q   <= ck_meta_q;
      ck_prev_q   <= ck_sync_q;
      rows_meta_q <= rows;
      rows_s_q    <= rows_meta_q;
    end
  end

  assign tick     = ck_sync_q & ~ck_prev_q;
  assign any_low  = (rows_s_q != 4'hF);
  assign cnt_inc  = cnt_q + ONE;
  assign cand_rel = rows_s_q[cand_q[3:2]];

  // Row 0 wins when several rows are low in the driven column.
  always_comb begin
    det_row = 2'd0;
    if      (!rows_s_q[0]) det_row = 2'd0;
    else if (!rows_s_q[1]) det_row = 2'd1;
    else if (!rows_s_q[2]) det_row = 2'd2;
    else if (!rows_s_q[3]) det_row = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      cnt_q   <= '0;
      cand_q  <= 4'h0;
      code_q  <= 4'h0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      held_q  <= held_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (!any_low) begin
            col_d = col_q + 2'd1;
          end else begin
            cand_d  = {det_row, col_q};
            cnt_d   = ONE;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (any_low && det_row == cand_q[3:2]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Only the accepted key's row matters here; any low restarts the release run.
          cnt_d = cand_rel ? cnt_inc : '0;
          if (cand_rel && cnt_inc == DB) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    cols      = ~(4'b0001 << col_q);
    key_code  = code_q;
    key_valid = valid_q;
    key_held  = held_q;
  end
endmodule
